// File: rtl/issue_controller_pkg.sv
// Shared ISA field codes, FSM encodings and register-use decode for the issue path.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package issue_controller_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] SPECIAL_JR   = 6'h08;
    localparam logic [5:0] SPECIAL_JALR = 6'h09;
    localparam logic [4:0] JAL_LINK_REG = 5'd31;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_BR_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    typedef struct packed {
        logic       rs_used;
        logic       rt_used;
        logic       dest_we;
        logic       mem_lat;
        logic [4:0] dest;
    } reg_use_t;

    // dest_we is only raised for a nonzero destination, so r0 never reaches the scoreboard.
    function automatic reg_use_t decode_reg_use(input logic [5:0] opcode,
                                                input logic [5:0] funct,
                                                input logic [4:0] rt,
                                                input logic [4:0] rd);
        reg_use_t u;
        logic     has_dest;
        u        = '0;
        has_dest = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                u.rs_used = 1'b1;
                if (funct == SPECIAL_JALR) begin
                    has_dest = 1'b1;
                    u.dest   = rd;
                end else if (funct != SPECIAL_JR) begin
                    u.rt_used = 1'b1;
                    has_dest  = 1'b1;
                    u.dest    = rd;
                end
            end
            OP_REGIMM, OP_BLEZ, OP_BGTZ: u.rs_used = 1'b1;
            OP_BEQ, OP_BNE: begin
                u.rs_used = 1'b1;
                u.rt_used = 1'b1;
            end
            OP_JAL: begin
                has_dest = 1'b1;
                u.dest   = JAL_LINK_REG;
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_XORI: begin
                u.rs_used = 1'b1;
                has_dest  = 1'b1;
                u.dest    = rt;
            end
            OP_LUI: begin
                has_dest  = 1'b1;
                u.dest    = rt;
                u.mem_lat = 1'b1;
            end
            OP_LW, OP_LB, OP_LBU: begin
                u.rs_used = 1'b1;
                has_dest  = 1'b1;
                u.dest    = rt;
                u.mem_lat = 1'b1;
            end
            OP_SW, OP_SB: begin
                u.rs_used = 1'b1;
                u.rt_used = 1'b1;
            end
            default: has_dest = 1'b0;
        endcase
        u.dest_we = has_dest && (u.dest != 5'd0);
        return u;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write down-counters; busy = counter nonzero.
// Latency: set takes effect on the next cycle; busy_mask is a direct decode of the counters.
// Backpressure: none; a set on an entry overrides that entry's decrement.
module reg_scoreboard #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en,
    input  logic [4:0]       set_addr,
    input  logic [CNT_W-1:0] set_value,
    output logic [31:0]      busy_mask
);

    logic [CNT_W-1:0] cnt [32];

    // Entry 0 is held at zero: r0 is never tracked.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (set_en && (set_addr == 5'(i))) begin
                    cnt[i] <= set_value;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < 32; i++) busy_mask[i] = (cnt[i] != '0);
    end

endmodule

// File: rtl/issue_controller.sv
// Issues decoded instructions, stalling on RAW/WAW hazards and unresolved branches.
// Latency: issue/stall/dest are combinational; w_flush is registered and lasts FLUSH_CYCLES.
// Backpressure: w_instr_valid is held by the decoder until w_issue; w_stall marks a held instruction.
module issue_controller
    import issue_controller_pkg::*;
#(
    parameter int ALU_LAT      = 1,
    parameter int MEM_LAT      = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        w_instr_valid,
    input  logic [31:0] w_instr_32,
    input  logic        w_alu_op,
    input  logic        w_mem_op,
    input  logic        w_branch_op,
    input  logic        w_nop,
    input  logic        w_branch_resolve,
    input  logic        w_branch_taken,
    output logic        w_issue,
    output logic        w_stall,
    output logic        w_flush,
    output logic        w_dest_we,
    output logic [4:0]  w_dest_addr_5,
    output logic [31:0] w_busy_mask_32,
    output logic [1:0]  w_state_2
);

    localparam logic [2:0] ALU_SET    = 3'(ALU_LAT);
    localparam logic [2:0] MEM_SET    = 3'(MEM_LAT);
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  flush_cnt;
    logic        flush_q;
    logic [4:0]  rs;
    logic [4:0]  rt;
    reg_use_t    use_q;
    logic [31:0] busy;
    logic        hazard;
    logic        issue_c;
    logic        stall_c;
    logic        set_en;

    // Register usage and latency class come from the opcode, so the ALU/mem flags are redundant here.
    logic unused_fields;
    assign unused_fields = ^{w_alu_op, w_mem_op, w_instr_32[10:6]};

    assign rs    = w_instr_32[25:21];
    assign rt    = w_instr_32[20:16];
    assign use_q = decode_reg_use(w_instr_32[31:26], w_instr_32[5:0], rt, w_instr_32[15:11]);

    // busy reflects counters before this cycle's decrement, so a count of 1 still blocks.
    assign hazard = (use_q.rs_used && (rs != 5'd0) && busy[rs])
                  || (use_q.rt_used && (rt != 5'd0) && busy[rt])
                  || (use_q.dest_we && busy[use_q.dest]);

    always_comb begin
        issue_c = 1'b0;
        stall_c = 1'b0;
        if (!reset && w_instr_valid) begin
            case (state)
                ST_RUN: begin
                    if (w_nop || !hazard) issue_c = 1'b1;
                    else                  stall_c = 1'b1;
                end
                ST_BR_WAIT: stall_c = 1'b1;
                default:    stall_c = 1'b0;
            endcase
        end
    end

    assign set_en = issue_c && !w_nop && use_q.dest_we;

    reg_scoreboard #(
        .CNT_W (3)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (set_en),
        .set_addr  (use_q.dest),
        .set_value (use_q.mem_lat ? MEM_SET : ALU_SET),
        .busy_mask (busy)
    );

    // A resolve in the branch's own issue cycle is seen in RUN and therefore ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            flush_q   <= 1'b0;
            flush_cnt <= 2'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (issue_c && w_branch_op && !w_nop) state <= ST_BR_WAIT;
                end
                ST_BR_WAIT: begin
                    if (w_branch_resolve) begin
                        if (w_branch_taken) begin
                            state     <= ST_FLUSH;
                            flush_q   <= 1'b1;
                            flush_cnt <= FLUSH_LOAD;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == 2'd0) begin
                        state   <= ST_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 2'd1;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    flush_q   <= 1'b0;
                    flush_cnt <= 2'd0;
                end
            endcase
        end
    end

    assign w_issue        = issue_c;
    assign w_stall        = stall_c;
    assign w_flush        = flush_q;
    assign w_dest_we      = set_en;
    assign w_dest_addr_5  = set_en ? use_q.dest : 5'd0;
    assign w_busy_mask_32 = busy;
    assign w_state_2      = state;

endmodule

// File: tb/tb_issue_controller.sv
// Randomized bench: timestamp-based reference model feeds expectation queues drained by a monitor.
module tb_issue_controller;
    import issue_controller_pkg::*;

    localparam int ALU_LAT      = 1;
    localparam int MEM_LAT      = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int RST_CYC      = 2;
    localparam int MAX_CYC      = 20000;

    localparam int K_ADDU = 0, K_ADDIU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_LB = 5;
    localparam int K_SW = 6, K_SB = 7, K_BEQ = 8, K_BNE = 9, K_BGTZ = 10, K_REGIMM = 11;
    localparam int K_J = 12, K_JAL = 13, K_JR = 14, K_JALR = 15, K_NOP = 16, K_SLTIU = 17;
    localparam int K_LBU = 18, K_NUM = 19;

    logic        clock = 1'b0;
    logic        reset;
    logic        w_instr_valid;
    logic [31:0] w_instr_32;
    logic        w_alu_op, w_mem_op, w_branch_op, w_nop;
    logic        w_branch_resolve, w_branch_taken;
    logic        w_issue, w_stall, w_flush, w_dest_we;
    logic [4:0]  w_dest_addr_5;
    logic [31:0] w_busy_mask_32;
    logic [1:0]  w_state_2;

    issue_controller #(
        .ALU_LAT      (ALU_LAT),
        .MEM_LAT      (MEM_LAT),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .w_instr_valid    (w_instr_valid),
        .w_instr_32       (w_instr_32),
        .w_alu_op         (w_alu_op),
        .w_mem_op         (w_mem_op),
        .w_branch_op      (w_branch_op),
        .w_nop            (w_nop),
        .w_branch_resolve (w_branch_resolve),
        .w_branch_taken   (w_branch_taken),
        .w_issue          (w_issue),
        .w_stall          (w_stall),
        .w_flush          (w_flush),
        .w_dest_we        (w_dest_we),
        .w_dest_addr_5    (w_dest_addr_5),
        .w_busy_mask_32   (w_busy_mask_32),
        .w_state_2        (w_state_2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        bit alu, mem, br, nop;
        int nsrc, src0, src1;
        bit dwe;
        int dest, lat, gap, res_delay;
        bit res_taken;
    } ent_t;

    typedef struct {
        int cyc;
        bit issue, stall, flush, dwe;
        logic [31:0] mask;
        int state;
    } cyc_rec_t;

    typedef struct {
        int cyc;
        bit dwe;
        int addr;
    } iss_rec_t;

    ent_t     prog[$];
    cyc_rec_t recq[$];
    iss_rec_t issq[$];

    int checks = 0;
    int failures = 0;
    bit run_on = 0;

    // Reference model: per-register cycle at which the value becomes readable, plus a coarse mode.
    int ready_at[32];
    int cyc;
    int mode;          // 0 run, 1 waiting on branch, 2 flushing
    int flush_left;
    int br_issue_cyc, br_delay;
    bit br_taken;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t act=0x%0h exp=0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit is_busy(int r);
        return (r != 0) && (ready_at[r] > cyc);
    endfunction

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
        return {OP_SPECIAL, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt);
        logic [15:0] imm;
        imm = 16'($urandom);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic int rreg();
        int r;
        r = int'($urandom_range(0, 8));
        return (r == 8) ? 31 : r;
    endfunction

    function automatic ent_t mk(int kind, int a, int b, int c);
        ent_t e;
        logic [25:0] tgt;
        tgt = 26'($urandom);
        e.word = $urandom; e.alu = 0; e.mem = 0; e.br = 0; e.nop = 0;
        e.nsrc = 0; e.src0 = 0; e.src1 = 0; e.dwe = 0; e.dest = 0; e.lat = ALU_LAT;
        e.gap = 0; e.res_delay = 1; e.res_taken = 0;
        case (kind)
            K_ADDU:  begin e.word = enc_r(b, c, a, 6'h21); e.alu = 1; e.nsrc = 2; e.src0 = b; e.src1 = c; e.dwe = 1; e.dest = a; end
            K_ADDIU: begin e.word = enc_i(OP_ADDIU, b, a); e.alu = 1; e.nsrc = 1; e.src0 = b; e.dwe = 1; e.dest = a; end
            K_ORI:   begin e.word = enc_i(OP_ORI, b, a);   e.alu = 1; e.nsrc = 1; e.src0 = b; e.dwe = 1; e.dest = a; end
            K_SLTIU: begin e.word = enc_i(OP_SLTIU, b, a); e.alu = 1; e.nsrc = 1; e.src0 = b; e.dwe = 1; e.dest = a; end
            K_LUI:   begin e.word = enc_i(OP_LUI, c, a);   e.alu = 1; e.dwe = 1; e.dest = a; e.lat = MEM_LAT; end
            K_LW:    begin e.word = enc_i(OP_LW, b, a);    e.mem = 1; e.nsrc = 1; e.src0 = b; e.dwe = 1; e.dest = a; e.lat = MEM_LAT; end
            K_LB:    begin e.word = enc_i(OP_LB, b, a);    e.mem = 1; e.nsrc = 1; e.src0 = b; e.dwe = 1; e.dest = a; e.lat = MEM_LAT; end
            K_LBU:   begin e.word = enc_i(OP_LBU, b, a);   e.mem = 1; e.nsrc = 1; e.src0 = b; e.dwe = 1; e.dest = a; e.lat = MEM_LAT; end
            K_SW:    begin e.word = enc_i(OP_SW, b, a);    e.mem = 1; e.nsrc = 2; e.src0 = b; e.src1 = a; end
            K_SB:    begin e.word = enc_i(OP_SB, b, a);    e.mem = 1; e.nsrc = 2; e.src0 = b; e.src1 = a; end
            K_BEQ:   begin e.word = enc_i(OP_BEQ, a, b);   e.br = 1; e.nsrc = 2; e.src0 = a; e.src1 = b; end
            K_BNE:   begin e.word = enc_i(OP_BNE, a, b);   e.br = 1; e.nsrc = 2; e.src0 = a; e.src1 = b; end
            K_BGTZ:  begin e.word = enc_i(OP_BGTZ, a, c);  e.br = 1; e.nsrc = 1; e.src0 = a; end
            K_REGIMM: begin e.word = enc_i(OP_REGIMM, a, 1); e.br = 1; e.nsrc = 1; e.src0 = a; end
            K_J:     begin e.word = {OP_J, tgt};   e.br = 1; end
            K_JAL:   begin e.word = {OP_JAL, tgt}; e.br = 1; e.dwe = 1; e.dest = 31; end
            K_JR:    begin e.word = enc_r(a, c, 0, SPECIAL_JR);   e.br = 1; e.mem = 1; e.nsrc = 1; e.src0 = a; end
            K_JALR:  begin e.word = enc_r(b, 0, a, SPECIAL_JALR); e.br = 1; e.mem = 1; e.nsrc = 1; e.src0 = b; e.dwe = 1; e.dest = a; end
            default: e.nop = 1;
        endcase
        return e;
    endfunction

    function automatic ent_t mkb(int kind, int a, int b, int dly, bit tk);
        ent_t e;
        e = mk(kind, a, b, 0);
        e.res_delay = dly;
        e.res_taken = tk;
        return e;
    endfunction

    // Monitor: one per-cycle record every cycle, one issue record whenever the DUT issues.
    initial begin
        cyc_rec_t r;
        iss_rec_t q;
        forever begin
            @(negedge clock);
            if (run_on) begin
                if (recq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cycle_queue empty t=%0t", $time);
                end else begin
                    r = recq.pop_front();
                    chk("issue", 32'(w_issue), 32'(r.issue));
                    chk("stall", 32'(w_stall), 32'(r.stall));
                    chk("flush", 32'(w_flush), 32'(r.flush));
                    chk("dest_we", 32'(w_dest_we), 32'(r.dwe));
                    chk("busy_mask", w_busy_mask_32, r.mask);
                    chk("state", 32'(w_state_2), 32'(r.state));
                    if (w_issue) begin
                        if (issq.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL issue_queue empty t=%0t", $time);
                        end else begin
                            q = issq.pop_front();
                            chk("issue_cycle", 32'(q.cyc), 32'(r.cyc));
                            chk("dest_addr", 32'(w_dest_addr_5), 32'(q.addr));
                        end
                    end
                end
            end
        end
    end

    initial begin
        ent_t     e;
        cyc_rec_t rec;
        iss_rec_t ir;
        int idx, gap_left, tail;
        bit valid, hz, issue, stall, dwe_eff;

        reset = 1'b1;
        w_instr_valid = 1'b1;
        w_instr_32 = enc_i(OP_ADDIU, 0, 2);
        w_alu_op = 1'b1; w_mem_op = 1'b0; w_branch_op = 1'b0; w_nop = 1'b0;
        w_branch_resolve = 1'b0; w_branch_taken = 1'b0;

        // Mid-stream reset setup: r2 pending from a load while a branch waits.
        prog.push_back(mk(K_LW, 2, 1, 0));
        prog.push_back(mkb(K_BEQ, 0, 0, 100, 1'b0));
        // RAW on an ALU result, then load-use.
        prog.push_back(mk(K_ADDIU, 2, 0, 0));
        prog.push_back(mk(K_ADDU, 3, 2, 2));
        prog.push_back(mk(K_LW, 4, 1, 0));
        prog.push_back(mk(K_SW, 4, 1, 0));
        // Taken branch resolved 3 cycles after issue, then a not-taken one.
        prog.push_back(mkb(K_BEQ, 1, 1, 3, 1'b1));
        prog.push_back(mk(K_ADDIU, 7, 0, 0));
        prog.push_back(mkb(K_BNE, 1, 0, 2, 1'b0));
        prog.push_back(mk(K_ADDIU, 8, 0, 0));
        // r0 is never tracked; WAW on r6.
        prog.push_back(mk(K_ADDIU, 0, 0, 0));
        prog.push_back(mk(K_ADDU, 5, 0, 0));
        prog.push_back(mk(K_LW, 6, 1, 0));
        prog.push_back(mk(K_ADDIU, 6, 0, 0));
        // Link register then JR on it.
        prog.push_back(mkb(K_JAL, 0, 0, 1, 1'b0));
        prog.push_back(mkb(K_JR, 31, 0, 2, 1'b1));
        prog.push_back(mk(K_NOP, 0, 0, 0));
        for (int n = 0; n < 300; n++) begin
            e = mk(int'($urandom_range(0, K_NUM - 1)), rreg(), rreg(), rreg());
            e.gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            e.res_delay = int'($urandom_range(1, 4));
            e.res_taken = ($urandom_range(0, 1) == 1);
            prog.push_back(e);
        end

        repeat (2) @(posedge clock);
        #1;
        chk("rst_issue", 32'(w_issue), 32'd0);
        chk("rst_stall", 32'(w_stall), 32'd0);
        chk("rst_flush", 32'(w_flush), 32'd0);
        chk("rst_dest_we", 32'(w_dest_we), 32'd0);
        chk("rst_dest_addr", 32'(w_dest_addr_5), 32'd0);
        chk("rst_busy", w_busy_mask_32, 32'd0);
        chk("rst_state", 32'(w_state_2), 32'(ST_RUN));

        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        cyc = 0; mode = 0; flush_left = 0;
        br_issue_cyc = 0; br_delay = 1; br_taken = 0;
        idx = 0; tail = 0;
        gap_left = prog[0].gap;

        while (cyc < MAX_CYC && tail < 8) begin
            @(posedge clock);
            #1;
            reset = 1'b0;
            valid = (idx < prog.size()) && (gap_left == 0);
            if (valid) begin
                e = prog[idx];
            end else begin
                e = mk(K_NOP, 0, 0, 0);
                e.nop = ($urandom_range(0, 1) == 1);
                e.br  = ($urandom_range(0, 1) == 1);
                e.alu = ($urandom_range(0, 1) == 1);
            end
            w_instr_valid = valid;
            w_instr_32 = e.word;
            w_alu_op = e.alu; w_mem_op = e.mem; w_branch_op = e.br; w_nop = e.nop;
            if (mode == 1) begin
                w_branch_resolve = (cyc - br_issue_cyc >= br_delay);
                w_branch_taken   = br_taken;
            end else begin
                w_branch_resolve = ($urandom_range(0, 7) == 0);
                w_branch_taken   = ($urandom_range(0, 1) == 1);
            end

            hz = 0;
            if (e.nsrc >= 1 && is_busy(e.src0)) hz = 1;
            if (e.nsrc >= 2 && is_busy(e.src1)) hz = 1;
            if (e.dwe && is_busy(e.dest)) hz = 1;
            issue = valid && (mode == 0) && (e.nop || !hz);
            stall = valid && !issue && (mode != 2);
            dwe_eff = issue && !e.nop && e.dwe && (e.dest != 0);

            rec.cyc = cyc; rec.issue = issue; rec.stall = stall; rec.dwe = dwe_eff;
            rec.flush = (mode == 2); rec.state = mode; rec.mask = '0;
            for (int r = 1; r < 32; r++) rec.mask[r] = is_busy(r);

            if (cyc == RST_CYC) begin
                rec.issue = 0; rec.stall = 0; rec.dwe = 0; rec.flush = 0;
                rec.state = 0; rec.mask = '0;
                recq.push_back(rec);
                run_on = 1;
                chk("pre_rst_busy", w_busy_mask_32, 32'h0000_0004);
                chk("pre_rst_state", 32'(w_state_2), 32'(ST_BR_WAIT));
                reset = 1'b1;
                #1;
                chk("mid_rst_busy", w_busy_mask_32, 32'd0);
                chk("mid_rst_flush", 32'(w_flush), 32'd0);
                chk("mid_rst_state", 32'(w_state_2), 32'(ST_RUN));
                chk("mid_rst_issue", 32'(w_issue), 32'd0);
                for (int r = 0; r < 32; r++) ready_at[r] = 0;
                mode = 0; flush_left = 0;
            end else begin
                recq.push_back(rec);
                if (issue) begin
                    ir.cyc = cyc; ir.dwe = dwe_eff; ir.addr = dwe_eff ? e.dest : 0;
                    issq.push_back(ir);
                end
                run_on = 1;
                case (mode)
                    0: begin
                        if (issue) begin
                            if (dwe_eff) ready_at[e.dest] = cyc + e.lat + 1;
                            if (e.br && !e.nop) begin
                                mode = 1; br_issue_cyc = cyc;
                                br_delay = e.res_delay; br_taken = e.res_taken;
                            end
                        end
                    end
                    1: begin
                        if (w_branch_resolve) begin
                            mode = w_branch_taken ? 2 : 0;
                            flush_left = FLUSH_CYCLES;
                        end
                    end
                    default: begin
                        flush_left--;
                        if (flush_left == 0) mode = 0;
                    end
                endcase
                if (issue) begin
                    idx++;
                    gap_left = (idx < prog.size()) ? prog[idx].gap : 0;
                end else if (!valid && gap_left > 0) begin
                    gap_left--;
                end
            end
            cyc++;
            if (idx >= prog.size()) tail++;
        end

        @(negedge clock);
        #1;
        run_on = 0;
        chk("prog_done", 32'(idx), 32'(prog.size()));
        chk("cycle_queue_drained", 32'(recq.size()), 32'd0);
        chk("issue_queue_drained", 32'(issq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
